tdm_demux_1_to_4: RTL
=====================

Name: tdm_demux_1_to_4

Overview:
- Receive-side counterpart of the 4-to-1 channel mux.
- Accepts a time-division-multiplexed stream of WIDTH-bit samples, one channel slot per valid beat, with a frame sync marking slot 0.
- Steers each sample to its channel holding register and presents a complete four-channel frame with a one-cycle strobe.
- Sits between the serial/TDM link and the per-channel consumers.

Parameters:
- WIDTH, 1, sample width in bits per channel.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  multiplexed sample for the current slot.
- din_valid  input  1  din and sync are meaningful this cycle.
- sync  input  1  qualified by din_valid; marks the slot-0 beat.
- dout  output  4*WIDTH  last complete frame; channel k at dout[k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when dout is updated.
- locked  output  1  high while in LOCKED.
- slot  output  2  slot index expected on the next valid beat.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low, asynchronous): state=HUNT, slot=0, dout=0, shadow registers ch0..ch2=0, frame_valid=0, sync_err=0, locked=0.
- Reset mid-frame discards the partial frame; dout returns to 0.
- All outputs are registered. A beat occurs only on cycles with din_valid=1. Cycles with din_valid=0 change nothing; sync is ignored on them.

HUNT state:
- Beat with sync=0: discarded, no error.
- Beat with sync=1: din goes to shadow ch0, slot becomes 1, state goes to LOCKED.

LOCKED state, normal beat:
- Beat with slot==s (s in 1..2) and sync=0: din goes to shadow ch[s], slot becomes s+1.
- Beat with slot==3 and sync=0, at the same edge:
  - dout becomes {din, ch2, ch1, ch0}, with channel 3 in the MSBs.
  - frame_valid=1 for the following cycle only.
  - slot becomes 0.
- Latency: dout and frame_valid are visible the cycle after the slot-3 beat is sampled.

LOCKED state, slot==0 beat:
- sync=1: din goes to ch0, slot becomes 1; normal frame start.
- sync=0: lost alignment. sync_err pulses, the sample is discarded, state goes to HUNT, slot becomes 0, dout is held.

LOCKED state, early sync (beat with slot!=0 and sync=1):
- sync_err pulses and the partial frame is discarded (no frame_valid).
- The beat is taken as a new slot 0: din goes to ch0, slot becomes 1, state stays LOCKED.

Other rules:
- dout changes only on a completed frame; it holds between frames and across errors.
- frame_valid and sync_err are never high in the same cycle.
- Slot counter is 2 bits and wraps 3 to 0 only via frame completion.
- locked=1 exactly when state=LOCKED.

Test Plan:
- Basic frame, WIDTH=1:
  - Stimulus: after reset, beats (sync,din) = (1,0),(0,1),(0,1),(0,1) on consecutive cycles.
  - Response: next cycle dout=4'b1110 and frame_valid=1 for one cycle; locked=1; slot=0.
- Back-to-back frames with gaps:
  - Stimulus: frame 1110, then frame 1001 with din_valid=0 idle cycles inserted between beats.
  - Response: idles change nothing; dout=1110 is held until the fourth beat of frame 2, then dout=1001 with a single frame_valid pulse.
- Hunt discard:
  - Stimulus: after reset, three beats with sync=0, then a clean frame 0101.
  - Response: no frame_valid and no sync_err during the first three beats; then dout=0101.
- Early sync:
  - Stimulus: while locked, beats (1,1),(0,0),(1,1),(0,0),(0,0),(0,1).
  - Response: sync_err pulses on the third beat; no frame_valid for the aborted frame; then dout=4'b1001 (ch0=1, ch1=0, ch2=0, ch3=1).
- Missing sync:
  - Stimulus: after a complete frame, next beat has sync=0.
  - Response: sync_err pulses, locked=0, dout is unchanged, and subsequent sync=0 beats are ignored until sync=1.
- Async reset mid-frame:
  - Stimulus: after 2 beats of a frame, pulse rst_n low between clock edges.
  - Response: dout=0, slot=0, locked=0 immediately, with no clock needed; after release, a fresh frame 0111 gives dout=0111.

Source files
------------

// File: rtl/tdm_demux_1_to_4.sv
// Receive-side TDM demultiplexer: aligns on a slot-0 frame sync and steers four
// channel samples into a registered frame presented with a one-cycle strobe.
module tdm_demux_1_to_4 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sync,
    output logic [4*WIDTH-1:0]   dout,
    output logic                 frame_valid,
    output logic                 locked,
    output logic [1:0]           slot,
    output logic                 sync_err
);

    localparam int unsigned FRAME_W = 4 * WIDTH;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         r_state;
    logic [1:0]         r_slot;
    logic [WIDTH-1:0]   r_ch0;
    logic [WIDTH-1:0]   r_ch1;
    logic [WIDTH-1:0]   r_ch2;
    logic [FRAME_W-1:0] r_dout;
    logic               r_frame_valid;
    logic               r_sync_err;

    logic [0:0]         w_state_nxt;
    logic [1:0]         w_slot_nxt;
    logic [WIDTH-1:0]   w_ch0_nxt;
    logic [WIDTH-1:0]   w_ch1_nxt;
    logic [WIDTH-1:0]   w_ch2_nxt;
    logic [FRAME_W-1:0] w_dout_nxt;
    logic               w_frame_valid_nxt;
    logic               w_sync_err_nxt;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_slot        <= 2'd0;
            r_ch0         <= '0;
            r_ch1         <= '0;
            r_ch2         <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_ch0         <= w_ch0_nxt;
            r_ch1         <= w_ch1_nxt;
            r_ch2         <= w_ch2_nxt;
            r_dout        <= w_dout_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
        end
    end

    // Framing decisions; only valid beats advance anything
    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_ch0_nxt         = r_ch0;
        w_ch1_nxt         = r_ch1;
        w_ch2_nxt         = r_ch2;
        w_dout_nxt        = r_dout;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;

        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (sync) begin
                        w_ch0_nxt   = din;
                        w_slot_nxt  = 2'd1;
                        w_state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (sync) begin
                        // An early sync restarts the frame on this beat
                        w_sync_err_nxt = (r_slot != 2'd0);
                        w_ch0_nxt      = din;
                        w_slot_nxt     = 2'd1;
                    end else begin
                        case (r_slot)
                            2'd0: begin
                                w_sync_err_nxt = 1'b1;
                                w_slot_nxt     = 2'd0;
                                w_state_nxt    = ST_HUNT;
                            end
                            2'd1: begin
                                w_ch1_nxt  = din;
                                w_slot_nxt = 2'd2;
                            end
                            2'd2: begin
                                w_ch2_nxt  = din;
                                w_slot_nxt = 2'd3;
                            end
                            default: begin
                                w_dout_nxt        = {din, r_ch2, r_ch1, r_ch0};
                                w_frame_valid_nxt = 1'b1;
                                w_slot_nxt        = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign locked      = (r_state == ST_LOCKED);
    assign slot        = r_slot;
    assign sync_err    = r_sync_err;

endmodule
